// File: rtl/vga_paletted_framebuffer.sv
// Avalon-MM paletted VGA framebuffer: double-buffered index memory, 24-bit palette,
// background colour outside the window, page flip aligned to the end of active video.
module vga_paletted_framebuffer #(
    parameter int FB_W     = 150,
    parameter int FB_H     = 480,
    parameter int X_OFF    = 245,
    parameter int PIX_W    = 4,
    parameter int ADDR_W   = 17,
    parameter int H_ACTIVE = 1280,
    parameter int H_FP     = 32,
    parameter int H_SYNC   = 192,
    parameter int H_BP     = 96,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        chipselect,
    input  logic        write,
    input  logic        read,
    input  logic [1:0]  address,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [7:0]  VGA_R,
    output logic [7:0]  VGA_G,
    output logic [7:0]  VGA_B,
    output logic        VGA_CLK,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        VGA_BLANK_n,
    output logic        VGA_SYNC_n
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DEPTH   = FB_W * FB_H;
    localparam int PAL_N   = 1 << PIX_W;

    logic [10:0]       hcount;
    logic [9:0]        vcount;
    logic [9:0]        px;
    logic              active;
    logic              in_window;
    logic              hs_raw;
    logic              vs_raw;
    logic              frame_end;

    logic              wr_pix;
    logic              wr_pal;
    logic              wr_bg;
    logic              wr_ctrl;
    logic [ADDR_W-1:0] pix_addr;
    logic              pix_ok;
    logic [7:0]        pal_idx;
    logic              pal_ok;
    logic              swap_now;

    logic [23:0]       bg;
    logic              front;
    logic              pending;
    logic              oob;
    logic [15:0]       frame_cnt;
    logic [23:0]       palette [PAL_N];

    logic [PIX_W-1:0]  bank0 [DEPTH];
    logic [PIX_W-1:0]  bank1 [DEPTH];
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] rd_addr;
    logic [PIX_W-1:0]  idx_q;
    logic              win1;
    logic              blank1;
    logic              hs1;
    logic              vs1;
    logic [23:0]       color;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hcount <= '0;
            vcount <= '0;
        end else if (hcount == 11'(H_TOTAL - 1)) begin
            hcount <= '0;
            vcount <= (vcount == 10'(V_TOTAL - 1)) ? 10'd0 : vcount + 10'd1;
        end else begin
            hcount <= hcount + 11'd1;
        end
    end

    assign px        = hcount[10:1];
    assign active    = (hcount < 11'(H_ACTIVE)) && (vcount < 10'(V_ACTIVE));
    assign in_window = active && (px >= 10'(X_OFF)) && (px < 10'(X_OFF + FB_W))
                       && (vcount < 10'(FB_H));
    assign hs_raw    = !((hcount >= 11'(H_ACTIVE + H_FP)) && (hcount < 11'(H_ACTIVE + H_FP + H_SYNC)));
    assign vs_raw    = !((vcount >= 10'(V_ACTIVE + V_FP)) && (vcount < 10'(V_ACTIVE + V_FP + V_SYNC)));
    assign frame_end = (hcount == 11'(H_TOTAL - 1)) && (vcount == 10'(V_ACTIVE - 1));

    assign wr_pix   = chipselect && write && (address == 2'd0);
    assign wr_pal   = chipselect && write && (address == 2'd1);
    assign wr_bg    = chipselect && write && (address == 2'd2);
    assign wr_ctrl  = chipselect && write && (address == 2'd3);
    assign pix_addr = writedata[ADDR_W+7:8];
    assign pix_ok   = 32'(pix_addr) < 32'(DEPTH);
    assign pal_idx  = writedata[31:24];
    assign pal_ok   = 32'(pal_idx) < 32'(PAL_N);
    // A request written on the boundary cycle itself still counts for that boundary.
    assign swap_now = pending || (wr_ctrl && writedata[0]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bg        <= 24'h000080;
            front     <= 1'b0;
            pending   <= 1'b0;
            oob       <= 1'b0;
            frame_cnt <= '0;
        end else begin
            if (wr_bg)
                bg <= writedata[23:0];
            if (frame_end) begin
                frame_cnt <= frame_cnt + 16'd1;
                if (swap_now) begin
                    front   <= ~front;
                    pending <= 1'b0;
                end
            end else if (wr_ctrl && writedata[0]) begin
                pending <= 1'b1;
            end
            if (wr_pix && !pix_ok)
                oob <= 1'b1;
            else if (wr_ctrl && writedata[2])
                oob <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < PAL_N; i++)
                palette[i] <= '0;
        end else if (wr_pal && pal_ok) begin
            palette[pal_idx[PIX_W-1:0]] <= writedata[23:0];
        end
    end

    // Writes always land in the bank the display is not scanning.
    always_ff @(posedge clk) begin
        if (wr_pix && pix_ok) begin
            if (front)
                bank0[pix_addr] <= writedata[PIX_W-1:0];
            else
                bank1[pix_addr] <= writedata[PIX_W-1:0];
        end
        idx_q <= front ? bank1[rd_addr] : bank0[rd_addr];
    end

    assign rd_addr = (32'(rd_ptr) < 32'(DEPTH)) ? rd_ptr : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            rd_ptr <= '0;
        else if (frame_end)
            rd_ptr <= '0;
        else if (in_window && hcount[0])
            rd_ptr <= rd_ptr + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            win1   <= 1'b0;
            blank1 <= 1'b0;
            hs1    <= 1'b1;
            vs1    <= 1'b1;
        end else begin
            win1   <= in_window;
            blank1 <= active;
            hs1    <= hs_raw;
            vs1    <= vs_raw;
        end
    end

    assign color = !blank1 ? 24'h0 : (win1 ? palette[idx_q] : bg);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            {VGA_R, VGA_G, VGA_B} <= '0;
            VGA_HS      <= 1'b1;
            VGA_VS      <= 1'b1;
            VGA_BLANK_n <= 1'b0;
        end else begin
            {VGA_R, VGA_G, VGA_B} <= color;
            VGA_HS      <= hs1;
            VGA_VS      <= vs1;
            VGA_BLANK_n <= blank1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            readdata <= '0;
        else if (chipselect && read) begin
            case (address)
                2'd2:    readdata <= {8'b0, bg};
                2'd3:    readdata <= {frame_cnt, 13'b0, oob, pending, front};
                default: readdata <= '0;
            endcase
        end else begin
            readdata <= '0;
        end
    end

    assign VGA_CLK    = hcount[0];
    assign VGA_SYNC_n = 1'b0;

endmodule

// File: tb/tb_vga_paletted_framebuffer.sv
// Bench for vga_paletted_framebuffer: a shrunken raster instance checked every cycle against
// a raster/palette model, plus a full-size instance for the real sync timing and overflow address.
module tb_vga_paletted_framebuffer;

    localparam int HA = 40, HFP = 4, HSY = 8, HBP = 8;
    localparam int VA = 12, VFP = 2, VSY = 2, VBP = 3;
    localparam int HT = HA + HFP + HSY + HBP;
    localparam int VT = VA + VFP + VSY + VBP;
    localparam int FRAME = HT * VT;
    localparam int FW = 8, FH = 10, XO = 5;
    localparam int DEPTH = FW * FH;
    localparam int BOUND = (VA - 1) * HT + HT - 1;
    localparam int VBLANK = (VA + 1) * HT;

    logic        clk = 1'b0;
    logic        reset;
    logic        cs, wr, rd;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [7:0]  r, g, b;
    logic        vclk, hs, vs, blank_n, sync_n;

    logic        f_cs, f_wr, f_rd;
    logic [1:0]  f_addr;
    logic [31:0] f_wdata;
    logic [31:0] f_rdata;
    logic [7:0]  f_r, f_g, f_b;
    logic        f_vclk, f_hs, f_vs, f_blank_n, f_sync_n;

    int checks = 0;
    int passes = 0;

    always #10 clk = ~clk;

    vga_paletted_framebuffer #(
        .FB_W(FW), .FB_H(FH), .X_OFF(XO), .PIX_W(4), .ADDR_W(7),
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP)
    ) dut (
        .clk(clk), .reset(reset), .chipselect(cs), .write(wr), .read(rd),
        .address(addr), .writedata(wdata), .readdata(rdata),
        .VGA_R(r), .VGA_G(g), .VGA_B(b), .VGA_CLK(vclk), .VGA_HS(hs), .VGA_VS(vs),
        .VGA_BLANK_n(blank_n), .VGA_SYNC_n(sync_n)
    );

    vga_paletted_framebuffer dut_full (
        .clk(clk), .reset(reset), .chipselect(f_cs), .write(f_wr), .read(f_rd),
        .address(f_addr), .writedata(f_wdata), .readdata(f_rdata),
        .VGA_R(f_r), .VGA_G(f_g), .VGA_B(f_b), .VGA_CLK(f_vclk), .VGA_HS(f_hs), .VGA_VS(f_vs),
        .VGA_BLANK_n(f_blank_n), .VGA_SYNC_n(f_sync_n)
    );

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp)
            passes++;
        else
            $display("[TB] FAIL %s: got %h, wanted %h at %0t", name, act, exp, $time);
    endtask

    // Model state: raster position of the current cycle and the two before it.
    int          pos, pos_d1, pos_d2;
    bit          v_d1, v_d2;
    logic [23:0] m_pal [16];
    logic [23:0] m_bg;
    bit          m_front, m_pending, m_oob;
    logic [15:0] m_fcnt;
    logic [3:0]  m_mem [2][DEPTH];
    bit          m_known [2][DEPTH];

    function automatic logic [31:0] m_status();
        return {m_fcnt, 13'b0, m_oob, m_pending, m_front};
    endfunction

    function automatic logic [23:0] col(input int i);
        return {4'(i), 4'h0, 8'hA0 ^ 8'(i), 8'(i * 7)};
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            pos = 0; pos_d1 = 0; pos_d2 = 0; v_d1 = 0; v_d2 = 0;
            for (int i = 0; i < 16; i++) m_pal[i] = 24'h0;
            m_bg = 24'h000080; m_front = 0; m_pending = 0; m_oob = 0; m_fcnt = 0;
        end else begin
            bit req;
            req = 0;
            if (cs && wr) begin
                case (addr)
                    2'd0: if (int'(wdata[14:8]) < DEPTH) begin
                              m_mem[!m_front][wdata[14:8]] = wdata[3:0];
                              m_known[!m_front][wdata[14:8]] = 1;
                          end else m_oob = 1;
                    2'd1: if (wdata[31:24] < 8'd16) m_pal[wdata[27:24]] = wdata[23:0];
                    2'd2: m_bg = wdata[23:0];
                    default: begin
                        req = wdata[0];
                        if (wdata[2]) m_oob = 0;
                    end
                endcase
            end
            if (pos == BOUND) begin
                m_fcnt = m_fcnt + 16'd1;
                if (m_pending || req) begin
                    m_front = !m_front;
                    m_pending = 0;
                end
            end else if (req) m_pending = 1;
            pos_d2 = pos_d1; v_d2 = v_d1;
            pos_d1 = pos;    v_d1 = 1;
            pos = (pos + 1) % FRAME;
        end
    end

    function automatic void model_out(input int p, output logic [23:0] rgb,
                                      output logic hs_e, output logic vs_e,
                                      output logic bl_e, output bit known);
        int h, v, x, a;
        h = p % HT; v = p / HT; x = h / 2;
        known = 1;
        hs_e = !(h >= HA + HFP && h < HA + HFP + HSY);
        vs_e = !(v >= VA + VFP && v < VA + VFP + VSY);
        bl_e = (h < HA) && (v < VA);
        if (!bl_e) rgb = 24'h0;
        else if (x >= XO && x < XO + FW && v < FH) begin
            a = v * FW + x - XO;
            known = m_known[m_front][a];
            rgb = m_pal[m_mem[m_front][a]];
        end else rgb = m_bg;
    endfunction

    always @(negedge clk) begin
        logic [23:0] e_rgb;
        logic e_hs, e_vs, e_bl;
        bit k;
        if (v_d2) model_out(pos_d2, e_rgb, e_hs, e_vs, e_bl, k);
        else begin e_rgb = 0; e_hs = 1; e_vs = 1; e_bl = 0; k = 1; end
        check_val("hs", 32'(hs), 32'(e_hs));
        check_val("vs", 32'(vs), 32'(e_vs));
        check_val("blank_n", 32'(blank_n), 32'(e_bl));
        if (k) check_val("rgb", 32'({r, g, b}), 32'(e_rgb));
        check_val("vga_clk", 32'(vclk), 32'((pos % HT) % 2));
        check_val("sync_n", 32'(sync_n), 32'(0));
    end

    task automatic wait_pos(input int target);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (pos != target && n < 2 * FRAME);
        if (pos != target) check_val("wait_pos_timeout", 32'(pos), 32'(target));
    endtask

    task automatic bus_write_now(input logic [1:0] a, input logic [31:0] d);
        cs = 1; wr = 1; addr = a; wdata = d;
        @(posedge clk);
        #1 cs = 0; wr = 0;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        bus_write_now(a, d);
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d, output logic [31:0] snap);
        @(negedge clk);
        snap = m_status();
        cs = 1; rd = 1; addr = a;
        @(posedge clk);
        #1 cs = 0; rd = 0;
        @(negedge clk);
        d = rdata;
    endtask

    task automatic full_bus(input logic [1:0] a, input logic [31:0] d, input bit is_read,
                            output logic [31:0] q);
        @(negedge clk);
        f_cs = 1; f_wr = !is_read; f_rd = is_read; f_addr = a; f_wdata = d;
        @(posedge clk);
        #1 f_cs = 0; f_wr = 0; f_rd = 0;
        @(negedge clk);
        q = f_rdata;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_rgb"}, 32'({r, g, b}), 32'h0);
        check_val({tag, "_hs"}, 32'(hs), 32'h1);
        check_val({tag, "_vs"}, 32'(vs), 32'h1);
        check_val({tag, "_blank"}, 32'(blank_n), 32'h0);
        check_val({tag, "_vclk"}, 32'(vclk), 32'h0);
        check_val({tag, "_readdata"}, rdata, 32'h0);
    endtask

    initial begin
        logic [31:0] d, snap, snap11;
        reset = 1; cs = 0; wr = 0; rd = 0; addr = 0; wdata = 0;
        f_cs = 0; f_wr = 0; f_rd = 0; f_addr = 0; f_wdata = 0;
        repeat (3) @(negedge clk);
        check_reset_outputs("init");
        reset = 0;

        // Full-size raster: sync and blank edges two clocks behind the counters.
        for (int c = 1; c <= 1506; c++) begin
            @(negedge clk);
            if (c == 2)    check_val("full_blank_on", 32'(f_blank_n), 32'h1);
            if (c == 1282) check_val("full_blank_off", 32'(f_blank_n), 32'h0);
            if (c == 1313) check_val("full_hs_before", 32'(f_hs), 32'h1);
            if (c == 1314) check_val("full_hs_start", 32'(f_hs), 32'h0);
            if (c == 1505) check_val("full_hs_end", 32'(f_hs), 32'h0);
            if (c == 1506) check_val("full_hs_after", 32'(f_hs), 32'h1);
        end
        full_bus(2'd0, (32'd72000 << 8) | 32'd5, 0, d);
        full_bus(2'd3, 32'h0, 1, d);
        check_val("full_oob_set", d, 32'h4);
        full_bus(2'd3, 32'h4, 0, d);
        full_bus(2'd3, 32'h0, 1, d);
        check_val("full_oob_clear", d, 32'h0);

        bus_read(2'd2, d, snap);
        check_val("bg_reset", d, 32'h000080);
        bus_read(2'd3, d, snap);
        check_val("status_model", d, snap);
        check_val("status_low_bits", {29'b0, d[2:0]}, 32'h0);

        // Palette 3 green, pixel 0 index 3 in back bank, swap.
        wait_pos(VBLANK);
        bus_write(2'd1, {8'd3, 24'h00ff00});
        bus_write(2'd0, 32'h3);
        bus_write(2'd3, 32'h1);
        wait_pos(BOUND);
        wait_pos(2 * (XO - 1) + 2);
        check_val("left_of_window_bg", 32'({r, g, b}), 32'h000080);
        wait_pos(2 * XO + 2);
        check_val("first_window_green", 32'({r, g, b}), 32'h00ff00);

        // Overflow address is dropped and sticks in status bit 2.
        bus_write(2'd0, (32'(DEPTH) << 8) | 32'h7);
        bus_read(2'd3, d, snap);
        check_val("oob_set", 32'(d[2]), 32'h1);
        check_val("oob_status_model", d, snap);
        bus_write(2'd3, 32'h4);
        bus_read(2'd3, d, snap);
        check_val("oob_clear", 32'(d[2]), 32'h0);

        // Swap requested mid-frame waits for the boundary (front is 1 here).
        wait_pos(5 * HT);
        bus_write(2'd3, 32'h1);
        bus_read(2'd3, d, snap);
        check_val("swap_pending", 32'(d[1:0]), 32'h3);
        wait_pos(11 * HT + 10);
        bus_read(2'd3, d, snap11);
        check_val("swap_no_tear", 32'(d[1:0]), 32'h3);
        wait_pos(BOUND);
        bus_read(2'd3, d, snap);
        check_val("swap_done", 32'(d[1:0]), 32'h0);
        check_val("fcnt_inc", 32'(d[31:16]), 32'(snap11[31:16] + 16'd1));
        check_val("swap_status_model", d, snap);

        // Request written on the boundary cycle itself.
        wait_pos(BOUND);
        bus_write_now(2'd3, 32'h1);
        bus_read(2'd3, d, snap);
        check_val("swap_at_boundary", 32'(d[1:0]), 32'h1);

        // Two requests in one frame give one flip.
        wait_pos(2 * HT);
        bus_write(2'd3, 32'h1);
        wait_pos(6 * HT);
        bus_write(2'd3, 32'h1);
        wait_pos(BOUND);
        bus_read(2'd3, d, snap);
        check_val("double_request_single_flip", 32'(d[1:0]), 32'h0);

        // Fill back bank with index = addr mod 16, distinct palette, swap.
        wait_pos(VBLANK);
        for (int i = 0; i < 16; i++) bus_write(2'd1, {8'(i), col(i)});
        for (int a = 0; a < DEPTH; a++) bus_write(2'd0, (32'(a) << 8) | 32'(a % 16));
        bus_write(2'd3, 32'h1);
        wait_pos(BOUND);
        wait_pos(2 * XO + 2);
        check_val("fill_first_pixel", 32'({r, g, b}), 32'(col(0)));
        wait_pos((FH - 1) * HT + 2 * (XO + FW - 1) + 2);
        check_val("fill_last_pixel", 32'({r, g, b}), 32'(col(((FH - 1) * FW + FW - 1) % 16)));

        // Reset mid-line: outputs drop at once, memory survives.
        wait_pos(5 * HT + 20);
        @(posedge clk);
        #2 reset = 1;
        #1 check_reset_outputs("midframe");
        @(negedge clk);
        @(negedge clk);
        reset = 0;
        bus_read(2'd3, d, snap);
        check_val("status_after_reset", d, 32'h0);
        wait_pos(BOUND);
        wait_pos(HT * 2);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
